seq_nonrestoring_divider: RTL

- Iterative signed 32-bit divider for the ALU, computing A / B with a start/done handshake.
- Uses one shared WIDTH+1-bit add/subtract datapath, one quotient bit per clock.
- Result is packed as {remainder, quotient} on a 2*WIDTH bus, so the register-file/HI-LO write path treats it the same way as the 64-bit adder and multiplier outputs.

---
 rtl/seq_nonrestoring_divider.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_nonrestoring_divider.sv
// seq_nonrestoring_divider: signed WIDTH-bit sequential non-restoring divider, one quotient bit per clock; ports clock, clear (async reset), start, A (dividend), B (divisor) -> busy, done pulse, div_by_zero, Z = {remainder, quotient}
module seq_nonrestoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   Z
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH:0] r, r_n, r_sh;
  logic [WIDTH-1:0] q, q_n, d, d_n, rem, quo;
  logic qneg, qneg_n, rneg, rneg_n, busy_n, done_n, dbz_n;
  logic [2*WIDTH-1:0] z_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    r_n = r;
    q_n = q;
    d_n = d;
    qneg_n = qneg;
    rneg_n = rneg;
    z_n = Z;
    done_n = 1'b0;
    dbz_n = 1'b0;
    r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
    rem = r[WIDTH] ? r[WIDTH-1:0] + d : r[WIDTH-1:0];
    quo = qneg ? -q : q;
    case (state)
      IDLE: if (start) begin
        if (B == '0) begin
          state_n = DONE;
          z_n = {A, {WIDTH{1'b1}}};
          done_n = 1'b1;
          dbz_n = 1'b1;
        end else begin
          state_n = DIVIDE;
          qneg_n = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_n = A[WIDTH-1];
          q_n = A[WIDTH-1] ? -A : A;
          d_n = B[WIDTH-1] ? -B : B;
          r_n = '0;
          cnt_n = '0;
        end
      end
      DIVIDE: begin
        r_n = r[WIDTH] ? r_sh + {1'b0, d} : r_sh - {1'b0, d};
        q_n = {q[WIDTH-2:0], ~r_n[WIDTH]};
        if (cnt == CW'(WIDTH - 1)) state_n = FIX;
        else cnt_n = cnt + 1'b1;
      end
      FIX: begin
        r_n = r[WIDTH] ? r + {1'b0, d} : r;
        z_n = {rneg ? -rem : rem, quo};
        done_n = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == DIVIDE) || (state_n == FIX);
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      Z <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      r <= r_n;
      q <= q_n;
      d <= d_n;
      qneg <= qneg_n;
      rneg <= rneg_n;
      busy <= busy_n;
      done <= done_n;
      div_by_zero <= dbz_n;
      Z <= z_n;
    end
  end
endmodule
